// File: rtl/card_frame_tx.sv
// Framed UART transmitter for the card link: writes SOF, TYPE, LEN, payload and
// an XOR checksum into the UART TX FIFO, one byte per cycle that the FIFO accepts.
module card_frame_tx #(
  parameter int         MAX_PAYLOAD = 8,
  parameter logic [7:0] SOF_BYTE    = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_type,
  input  logic [3:0]               req_len,
  input  logic [8*MAX_PAYLOAD-1:0] req_payload,
  input  logic                     tx_full,
  output logic                     wr_uart,
  output logic [7:0]               w_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     err_len
);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_TYPE, S_LEN, S_PAYLOAD, S_CHK
  } state_t;

  localparam logic [3:0] MAX_LEN = 4'(MAX_PAYLOAD);

  state_t                   r_state;
  state_t                   w_next;
  logic [7:0]               r_type;
  logic [3:0]               r_len;
  logic [3:0]               r_idx;
  logic [7:0]               r_chk;
  logic [8*MAX_PAYLOAD-1:0] r_payload;
  logic                     r_done;
  logic                     r_err;
  logic                     w_accept;
  logic                     w_reject;
  logic                     w_last_pl;
  logic [7:0]               w_pl_byte;

  assign w_accept   = (r_state == S_IDLE) && req_valid && (req_len <= MAX_LEN);
  assign w_reject   = (r_state == S_IDLE) && req_valid && (req_len > MAX_LEN);
  assign w_last_pl  = (r_idx == r_len - 4'd1);
  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_done;
  assign err_len    = r_err;

  always_comb begin
    w_pl_byte = 8'h00;
    for (int i = 0; i < MAX_PAYLOAD; i++) begin
      if (r_idx == 4'(i)) w_pl_byte = r_payload[8*i +: 8];
    end
  end

  // Every non-idle state emits exactly one byte and advances only when it is written.
  always_comb begin
    w_next  = r_state;
    wr_uart = (r_state != S_IDLE) && !tx_full;
    w_data  = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_SOF;
      end
      S_SOF: begin
        w_data = SOF_BYTE;
        if (wr_uart) w_next = S_TYPE;
      end
      S_TYPE: begin
        w_data = r_type;
        if (wr_uart) w_next = S_LEN;
      end
      S_LEN: begin
        w_data = {4'b0000, r_len};
        if (wr_uart) w_next = (r_len != 4'd0) ? S_PAYLOAD : S_CHK;
      end
      S_PAYLOAD: begin
        w_data = w_pl_byte;
        if (wr_uart && w_last_pl) w_next = S_CHK;
      end
      S_CHK: begin
        w_data = r_chk;
        if (wr_uart) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_type    <= 8'h00;
      r_len     <= 4'd0;
      r_idx     <= 4'd0;
      r_chk     <= 8'h00;
      r_payload <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_CHK) && wr_uart;
      r_err   <= w_reject;
      if (w_accept) begin
        r_type    <= req_type;
        r_len     <= req_len;
        r_payload <= req_payload;
        r_chk     <= 8'h00;
        r_idx     <= 4'd0;
      end else if (wr_uart) begin
        // SOF is deliberately left out of the checksum.
        if (r_state == S_TYPE || r_state == S_LEN || r_state == S_PAYLOAD)
          r_chk <= r_chk ^ w_data;
        if (r_state == S_PAYLOAD)
          r_idx <= r_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_card_frame_tx.sv
// Directed bench for card_frame_tx: frame contents, stalls, length reject,
// asynchronous reset mid-frame and back-to-back requests.
module tb_card_frame_tx;

  localparam int MAXP = 8;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [7:0]      req_type;
  logic [3:0]      req_len;
  logic [8*MAXP-1:0] req_payload;
  logic            tx_full;
  logic            wr_uart;
  logic [7:0]      w_data;
  logic            busy;
  logic            frame_done;
  logic            err_len;

  card_frame_tx #(.MAX_PAYLOAD(MAXP), .SOF_BYTE(8'hA5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_type    (req_type),
    .req_len     (req_len),
    .req_payload (req_payload),
    .tx_full     (tx_full),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_len     (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] cap[$];
  logic [7:0] exp_q[$];
  int         wr_k[$];
  int         done_k;
  int         n_done;
  int         ready_hi;
  int         held_bad;
  int         stall_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      check($sformatf("%s_b%0d", tag, i), {24'h0, cap[i]}, {24'h0, exp_q[i]});
  endtask

  // Called at 1 time unit after an edge in IDLE; returns 1 unit after the accept edge.
  task automatic send(input logic [7:0] t, input logic [3:0] l,
                      input logic [8*MAXP-1:0] p, input bit hold);
    req_valid   = 1'b1;
    req_type    = t;
    req_len     = l;
    req_payload = p;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic capture(input int want_done, input int st_start, input int st_n,
                         input logic [7:0] hold_exp, input bit keep_valid);
    cap.delete(); wr_k.delete();
    done_k = -1; n_done = 0; ready_hi = 0; held_bad = 0; stall_cnt = 0;
    for (int k = 0; k < 60 && n_done < want_done; k++) begin
      tx_full = (k >= st_start) && (k < st_start + st_n);
      if (keep_valid) begin
        if (cap.size() >= 7) req_valid = 1'b0;
      end else begin
        req_type    = 8'hEE;
        req_len     = 4'hF;
        req_payload = '1;
      end
      #1;
      if (wr_uart) begin
        cap.push_back(w_data);
        wr_k.push_back(k);
      end
      if (tx_full) begin
        stall_cnt++;
        if (wr_uart) held_bad++;
        if (w_data !== hold_exp) held_bad++;
      end
      if (frame_done) begin
        n_done++;
        done_k = k;
      end else if (req_ready) begin
        ready_hi++;
      end
      @(posedge clk); #1;
    end
    tx_full   = 1'b0;
    req_valid = 1'b0;
    check("capture_timeout", n_done, want_done);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_type = 8'h00; req_len = 4'd0;
    req_payload = '0; tx_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_wr", wr_uart, 0);
    check("rst_wdata", w_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", err_len, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame, len 2
    send(8'h10, 4'd2, {48'h0, 8'h07, 8'h33}, 1'b0);
    capture(1, 99, 0, 8'h00, 1'b0);
    exp_q = {8'hA5, 8'h10, 8'h02, 8'h33, 8'h07, 8'h26};
    check_bytes("f1");
    check("f1_first_k", wr_k.size() > 0 ? wr_k[0] : -1, 0);
    check("f1_last_k", wr_k.size() > 5 ? wr_k[5] : -1, 5);
    check("f1_done_k", done_k, 6);
    check("f1_ready_low", ready_hi, 0);
    check("f1_busy_after", busy, 0);
    check("f1_done_pulse", frame_done, 0);

    // Zero-length frame
    send(8'h01, 4'd0, '0, 1'b0);
    capture(1, 99, 0, 8'h00, 1'b0);
    exp_q = {8'hA5, 8'h01, 8'h00, 8'h01};
    check_bytes("f0");
    check("f0_done_k", done_k, 4);
    check("f0_ndone", n_done, 1);

    // Stall 3 cycles while LEN is pending
    send(8'h10, 4'd2, {48'h0, 8'h07, 8'h33}, 1'b0);
    capture(1, 2, 3, 8'h02, 1'b0);
    exp_q = {8'hA5, 8'h10, 8'h02, 8'h33, 8'h07, 8'h26};
    check_bytes("fs");
    check("fs_stall_cycles", stall_cnt, 3);
    check("fs_held", held_bad, 0);
    check("fs_resume_k", wr_k.size() > 2 ? wr_k[2] : -1, 5);
    check("fs_done_k", done_k, 9);

    // Length reject
    req_valid = 1'b1; req_type = 8'h10; req_len = 4'd9; req_payload = '1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    check("err_pulse", err_len, 1);
    check("err_busy", busy, 0);
    check("err_ready", req_ready, 1);
    check("err_wr", wr_uart, 0);
    @(posedge clk); #1; #1;
    check("err_clear", err_len, 0);
    check("err_wr2", wr_uart, 0);
    check("err_busy2", busy, 0);
    @(posedge clk); #1;

    // Asynchronous reset after the TYPE byte
    send(8'h10, 4'd2, {48'h0, 8'h07, 8'h33}, 1'b0);
    #1;
    check("ar_sof_wr", wr_uart, 1);
    check("ar_sof", w_data, 8'hA5);
    @(posedge clk); #1; #1;
    check("ar_type", w_data, 8'h10);
    @(posedge clk); #1; #1;
    check("ar_len_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_wr", wr_uart, 0);
    check("ar_wdata", w_data, 8'h00);
    check("ar_ready", req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("ar_nodone%0d", i), frame_done, 0);
      @(posedge clk); #1;
    end
    send(8'h02, 4'd1, {56'h0, 8'hFF}, 1'b0);
    capture(1, 99, 0, 8'h00, 1'b0);
    exp_q = {8'hA5, 8'h02, 8'h01, 8'hFF, 8'hFC};
    check_bytes("ar_new");

    // Back-to-back with req_valid held
    send(8'h10, 4'd2, {48'h0, 8'h07, 8'h33}, 1'b1);
    capture(2, 99, 0, 8'h00, 1'b1);
    exp_q = {8'hA5, 8'h10, 8'h02, 8'h33, 8'h07, 8'h26,
             8'hA5, 8'h10, 8'h02, 8'h33, 8'h07, 8'h26};
    check_bytes("bb");
    check("bb_gap", wr_k.size() > 6 ? wr_k[6] - wr_k[5] : -1, 2);
    check("bb_done_k", done_k, 13);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
